// File: rtl/spi_arb_pkg.sv
// Shared state type, default widths and command-field helper for the SPI request arbiter.
package spi_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_CMD_WIDTH  = 12;
    localparam int unsigned DEF_READ_WIDTH = 8;
    localparam int unsigned DEF_TIMEOUT    = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Position of the write flag (1 = write, 0 = read) within a command word.
    function automatic int unsigned rw_bit(input int unsigned cmd_width);
        return cmd_width - 1;
    endfunction

endpackage

// File: rtl/spi_req_arbiter_rr_pick.sv
// Round-robin priority picker: first set request above last_grant, wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);

    int unsigned       pos;
    logic [IDXW-1:0]   p;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        p     = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            pos = 32'(last_grant) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            p = IDXW'(pos);
            if (!any && req[p]) begin
                any      = 1'b1;
                idx      = p;
                grant[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant, issue, completion tracking, watchdog.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned CMD_WIDTH  = DEF_CMD_WIDTH,
    parameter int unsigned READ_WIDTH = DEF_READ_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_vld,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [NUM_REQ-1:0]           rsp_vld,
    output logic [READ_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic [CMD_WIDTH-1:0]         m_cmd,
    output logic                         m_cmd_vld,
    input  logic                         m_cmd_rdy,
    input  logic                         m_read_vld,
    input  logic [READ_WIDTH-1:0]        m_read_data
);

    localparam int unsigned     IDXW    = $clog2(NUM_REQ);
    localparam int unsigned     CNTW    = $clog2(TIMEOUT + 1);
    localparam int unsigned     RW_BIT  = rw_bit(CMD_WIDTH);
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);

    arb_state_t           state;
    logic [IDXW-1:0]      last_grant;
    logic [IDXW-1:0]      owner;
    logic                 is_read;
    logic                 busy_seen;
    logic [CNTW-1:0]      wait_cnt;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDXW-1:0]      pick_idx;
    logic                 pick_any;
    logic [CMD_WIDTH-1:0] win_cmd;
    logic                 done;
    logic                 timed_out;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req        (req_vld),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        win_cmd = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                win_cmd = win_cmd | req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    // Accept strobe is combinational so the requester sees it in the cycle it is chosen.
    assign req_rdy   = (rst_n && state == IDLE) ? pick_grant : '0;

    assign done      = (state == WAIT) && (is_read ? m_read_vld : (m_cmd_rdy && busy_seen));
    assign timed_out = (state == WAIT) && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDXW'(NUM_REQ - 1);
            owner      <= '0;
            is_read    <= 1'b0;
            busy_seen  <= 1'b0;
            wait_cnt   <= '0;
            m_cmd      <= '0;
            m_cmd_vld  <= 1'b0;
            rsp_vld    <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_vld  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        m_cmd      <= win_cmd;
                        m_cmd_vld  <= 1'b1;
                        owner      <= pick_idx;
                        is_read    <= ~win_cmd[RW_BIT];
                        last_grant <= pick_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_cmd_rdy) begin
                        m_cmd_vld <= 1'b0;
                        busy_seen <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter parks at the abort threshold rather than wrapping.
                    if (wait_cnt != TO_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (!is_read && !m_cmd_rdy) begin
                        busy_seen <= 1'b1;
                    end
                    if (done) begin
                        rsp_vld  <= NUM_REQ'(1) << owner;
                        rsp_data <= is_read ? m_read_data : '0;
                        state    <= IDLE;
                    end else if (timed_out) begin
                        rsp_vld  <= NUM_REQ'(1) << owner;
                        rsp_err  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter with a behavioural SPI master and reference model.
module tb_spi_req_arbiter;

    localparam int N  = 4;
    localparam int CW = 12;
    localparam int RW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_vld = '0;
    logic [N*CW-1:0] req_cmd = '0;
    logic [N-1:0]  req_rdy;
    logic [N-1:0]  rsp_vld;
    logic [RW-1:0] rsp_data;
    logic          rsp_err;
    logic [CW-1:0] m_cmd;
    logic          m_cmd_vld;
    logic          m_cmd_rdy;
    logic          m_read_vld;
    logic [RW-1:0] m_read_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Master behaviour for the next handshake: read latency in WAIT cycles, write busy length, read data.
    int        rd_lat = 0;
    int        wr_busy = 1;
    logic [7:0] rd_data = '0;

    int        m_k = 0, m_lat = 0, m_busy = 0;
    logic [7:0] m_data = '0;
    bit        m_on = 0, m_rd = 0;

    spi_req_arbiter #(
        .NUM_REQ    (N),
        .CMD_WIDTH  (CW),
        .READ_WIDTH (RW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_cmd     (req_cmd),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .m_cmd       (m_cmd),
        .m_cmd_vld   (m_cmd_vld),
        .m_cmd_rdy   (m_cmd_rdy),
        .m_read_vld  (m_read_vld),
        .m_read_data (m_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI master: idle-ready, busy for m_busy cycles on writes, returns data after m_lat on reads.
    initial begin
        m_cmd_rdy   = 1'b1;
        m_read_vld  = 1'b0;
        m_read_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_on = 0;
            end else if (m_cmd_vld && m_cmd_rdy) begin
                m_on = 1; m_k = 0; m_rd = !m_cmd[CW-1];
                m_lat = rd_lat; m_busy = wr_busy; m_data = rd_data;
            end else if (m_on) begin
                m_k++;
            end
            @(posedge clk); #1;
            m_cmd_rdy  = 1'b1;
            m_read_vld = 1'b0;
            if (m_on && rst_n) begin
                if (m_rd) begin
                    if (m_k == m_lat) begin
                        m_read_vld = 1'b1; m_read_data = m_data; m_on = 0;
                    end
                end else if (m_k < m_busy) begin
                    m_cmd_rdy = 1'b0;
                end else begin
                    m_on = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic drive_pt();
        @(posedge clk); #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
    endtask

    task automatic set_cmd(input int i, input logic [CW-1:0] c);
        req_cmd[i*CW +: CW] = c;
    endtask

    task automatic do_reset();
        drive_pt(); rst_n = 1'b0; req_vld = '0;
        drive_pt(); drive_pt(); rst_n = 1'b1;
    endtask

    // Presents one request alone, returns req_rdy seen in the grant cycle and the handshake cycle number.
    task automatic issue(input int i, input logic [CW-1:0] c, output logic [N-1:0] rdy, output int hs);
        drive_pt(); set_cmd(i, c); req_vld = '0; req_vld[i] = 1'b1;
        sample_pt(); rdy = req_rdy;
        drive_pt(); req_vld = '0;
        sample_pt(); hs = cyc;
    endtask

    task automatic wait_rsp(input int limit, output bit seen, output int at);
        seen = 0; at = -1;
        for (int k = 0; k < limit; k++) begin
            sample_pt();
            if (rsp_vld !== '0) begin seen = 1; at = cyc; break; end
        end
    endtask

    task automatic test_reset();
        drive_pt(); rst_n = 1'b0; req_vld = '0;
        sample_pt();
        tests++; if (req_rdy !== '0)   begin fails++; $display("FAIL reset_req_rdy: got %b expected 0", req_rdy); end
        tests++; if (rsp_vld !== '0)   begin fails++; $display("FAIL reset_rsp_vld: got %b expected 0", rsp_vld); end
        tests++; if (rsp_data !== '0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp: data %h err %b expected 0/0", rsp_data, rsp_err); end
        tests++; if (m_cmd !== '0 || m_cmd_vld !== 1'b0) begin fails++; $display("FAIL reset_m_cmd: cmd %h vld %b expected 0/0", m_cmd, m_cmd_vld); end
        drive_pt(); rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic [N-1:0] rdy; int hs, at; bit seen;
        rd_lat = 3; rd_data = 8'h3C;
        issue(2, 12'h0A5, rdy, hs);
        tests++; if (rdy !== 4'b0100) begin fails++; $display("FAIL read_grant: got %b expected 0100", rdy); end
        tests++; if (m_cmd_vld !== 1'b1 || m_cmd !== 12'h0A5) begin fails++; $display("FAIL read_issue: vld %b cmd %h expected 1/0a5", m_cmd_vld, m_cmd); end
        wait_rsp(40, seen, at);
        tests++; if (!seen || at != hs + 5) begin fails++; $display("FAIL read_latency: rsp at %0d expected %0d", at, hs + 5); end
        tests++; if (rsp_vld !== 4'b0100 || rsp_data !== 8'h3C || rsp_err !== 1'b0) begin fails++; $display("FAIL read_rsp: vld %b data %h err %b expected 0100/3c/0", rsp_vld, rsp_data, rsp_err); end
        sample_pt();
        tests++; if (rsp_vld !== '0) begin fails++; $display("FAIL read_pulse: got %b expected 0", rsp_vld); end
    endtask

    task automatic test_single_write();
        logic [N-1:0] rdy; int hs, at; bit seen;
        wr_busy = 12;
        issue(0, 12'h8F1, rdy, hs);
        tests++; if (rdy !== 4'b0001 || m_cmd !== 12'h8F1) begin fails++; $display("FAIL write_grant: rdy %b cmd %h expected 0001/8f1", rdy, m_cmd); end
        wait_rsp(40, seen, at);
        tests++; if (!seen || at != hs + 14) begin fails++; $display("FAIL write_latency: rsp at %0d expected %0d", at, hs + 14); end
        tests++; if (rsp_vld !== 4'b0001 || rsp_data !== '0 || rsp_err !== 1'b0) begin fails++; $display("FAIL write_rsp: vld %b data %h err %b expected 0001/00/0", rsp_vld, rsp_data, rsp_err); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp; int n, last_at, at; bit seen;
        do_reset();
        wr_busy = 1;
        drive_pt();
        for (int i = 0; i < N; i++) set_cmd(i, CW'(12'h800 | i));
        req_vld = '1;
        n = 0; last_at = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            sample_pt();
            if (req_rdy !== '0) begin
                exp = '0; exp[n % N] = 1'b1;
                tests++; if (req_rdy !== exp) begin fails++; $display("FAIL fair_order[%0d]: got %b expected %b", n, req_rdy, exp); end
                if (n > 0) begin
                    tests++; if (cyc - last_at != 4) begin fails++; $display("FAIL fair_spacing[%0d]: got %0d expected 4", n, cyc - last_at); end
                    exp = '0; exp[(n - 1) % N] = 1'b1;
                    tests++; if (rsp_vld !== exp) begin fails++; $display("FAIL fair_overlap[%0d]: got %b expected %b", n, rsp_vld, exp); end
                end
                last_at = cyc; n++;
            end
        end
        tests++; if (n != 8) begin fails++; $display("FAIL fair_count: got %0d grants expected 8", n); end
        drive_pt(); req_vld = '0;
        wait_rsp(40, seen, at);
    endtask

    task automatic test_timeout();
        logic [N-1:0] rdy; int hs, at; bit seen;
        rd_lat = 9999;
        issue(1, 12'h012, rdy, hs);
        wait_rsp(60, seen, at);
        tests++; if (!seen || at != hs + 17) begin fails++; $display("FAIL timeout_latency: rsp at %0d expected %0d", at, hs + 17); end
        tests++; if (rsp_vld !== 4'b0010 || rsp_err !== 1'b1 || rsp_data !== '0) begin fails++; $display("FAIL timeout_rsp: vld %b err %b data %h expected 0010/1/00", rsp_vld, rsp_err, rsp_data); end
        rd_lat = 2; rd_data = 8'h5A;
        issue(3, 12'h345, rdy, hs);
        tests++; if (rdy !== 4'b1000) begin fails++; $display("FAIL after_timeout_grant: got %b expected 1000", rdy); end
        wait_rsp(40, seen, at);
        tests++; if (!seen || at != hs + 4 || rsp_vld !== 4'b1000 || rsp_data !== 8'h5A || rsp_err !== 1'b0) begin fails++; $display("FAIL after_timeout_rsp: at %0d vld %b data %h err %b expected %0d/1000/5a/0", at, rsp_vld, rsp_data, rsp_err, hs + 4); end
    endtask

    task automatic test_race();
        logic [N-1:0] rdy; int hs, at; bit seen;
        rd_lat = TO - 1; rd_data = 8'hA7;
        issue(0, 12'h7FF, rdy, hs);
        wait_rsp(60, seen, at);
        tests++; if (!seen || at != hs + 17) begin fails++; $display("FAIL race_latency: rsp at %0d expected %0d", at, hs + 17); end
        tests++; if (rsp_vld !== 4'b0001 || rsp_err !== 1'b0 || rsp_data !== 8'hA7) begin fails++; $display("FAIL race_rsp: vld %b err %b data %h expected 0001/0/a7", rsp_vld, rsp_err, rsp_data); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rdy; int hs, at, stray; bit seen;
        rd_lat = 9999;
        issue(2, 12'h0C3, rdy, hs);
        for (int k = 0; k < 5; k++) sample_pt();
        drive_pt(); rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_cmd(i, CW'(12'h010 + i));
        req_vld = '1;
        sample_pt();
        tests++; if (req_rdy !== '0 || rsp_vld !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 || m_cmd !== '0 || m_cmd_vld !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs: rdy %b rsp %b data %h err %b cmd %h vld %b expected all 0", req_rdy, rsp_vld, rsp_data, rsp_err, m_cmd, m_cmd_vld);
        end
        drive_pt(); drive_pt(); rst_n = 1'b1; req_vld = '0;
        stray = 0;
        for (int k = 0; k < 20; k++) begin sample_pt(); if (rsp_vld !== '0) stray++; end
        tests++; if (stray != 0) begin fails++; $display("FAIL midreset_no_rsp: got %0d rsp cycles expected 0", stray); end
        rd_lat = 1; rd_data = 8'h11;
        drive_pt(); req_vld = '1;
        sample_pt();
        tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL midreset_first_grant: got %b expected 0001", req_rdy); end
        drive_pt(); req_vld = '0;
        wait_rsp(40, seen, at);
    endtask

    task automatic test_random();
        bit [N-1:0]    pend;
        logic [CW-1:0] cmds [N];
        logic [N-1:0]  exp_rdy;
        logic [7:0]    exp_data;
        logic [CW-1:0] exp_cmd;
        bit            exp_err;
        int model_last, free_at, rsp_due, exp_own, iss_at, w, j, lat;
        do_reset();
        pend = '0; model_last = N - 1; free_at = 0; rsp_due = -1; iss_at = -1;
        exp_own = 0; exp_data = '0; exp_err = 0; exp_cmd = '0;
        for (int i = 0; i < N; i++) cmds[i] = '0;
        for (int t = 0; t < 2000; t++) begin
            drive_pt();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1; cmds[i] = CW'($urandom);
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 0;
                end
                set_cmd(i, cmds[i]);
            end
            req_vld = pend;
            sample_pt();
            if (cyc == rsp_due) begin
                tests++; if (rsp_vld !== (N'(1) << exp_own) || rsp_data !== exp_data || rsp_err !== exp_err) begin
                    fails++; $display("FAIL rand_rsp@%0d: vld %b data %h err %b expected %b/%h/%b", cyc, rsp_vld, rsp_data, rsp_err, N'(1) << exp_own, exp_data, exp_err);
                end
            end else begin
                tests++; if (rsp_vld !== '0) begin fails++; $display("FAIL rand_idle_rsp@%0d: got %b expected 0", cyc, rsp_vld); end
            end
            if (cyc == iss_at) begin
                tests++; if (m_cmd_vld !== 1'b1 || m_cmd !== exp_cmd) begin fails++; $display("FAIL rand_issue@%0d: vld %b cmd %h expected 1/%h", cyc, m_cmd_vld, m_cmd, exp_cmd); end
            end
            w = -1;
            if (cyc >= free_at) begin
                for (int k = 1; k <= N; k++) begin
                    j = (model_last + k) % N;
                    if (w < 0 && pend[j]) w = j;
                end
            end
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            tests++; if (req_rdy !== exp_rdy) begin fails++; $display("FAIL rand_grant@%0d: got %b expected %b", cyc, req_rdy, exp_rdy); end
            if (w >= 0) begin
                if (!cmds[w][CW-1]) begin
                    rd_lat = $urandom_range(0, 18); rd_data = 8'($urandom);
                    exp_err = rd_lat > TO - 1;
                    lat = exp_err ? TO - 1 : rd_lat;
                    exp_data = exp_err ? 8'h00 : rd_data;
                end else begin
                    wr_busy = $urandom_range(1, 13);
                    lat = wr_busy; exp_err = 0; exp_data = '0;
                end
                exp_cmd = cmds[w]; iss_at = cyc + 1;
                rsp_due = cyc + 3 + lat; free_at = rsp_due;
                exp_own = w; model_last = w; pend[w] = 0;
            end
        end
        drive_pt(); req_vld = '0;
        while (cyc <= free_at) sample_pt();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_timeout();
        test_race();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_req_arbiter.md
# spi_req_arbiter

Round-robin arbiter and sequencer that shares one SPI master (12-bit command in, 8-bit read data out, cmd_vld/cmd_rdy handshake) between NUM_REQ requesters. It accepts one command at a time and forwards it to the master. It then tracks completion: end of busy for writes, read_vld for reads. It returns a one-cycle response to the owning requester, and a watchdog aborts hung transactions. It sits between the register-access clients and the SPI master.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CMD_WIDTH, 12, command width; bit CMD_WIDTH-1 = 1 write, 0 read
- READ_WIDTH, 8, read data width
- TIMEOUT, 1023, cycles allowed in WAIT before abort (1..65535)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester command valid
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands; requester i at [i*CMD_WIDTH +: CMD_WIDTH]
- req_rdy  out  NUM_REQ  one-hot accept strobe
- rsp_vld  out  NUM_REQ  one-hot completion pulse, 1 cycle
- rsp_data  out  READ_WIDTH  read data; 0 for writes and aborts
- rsp_err  out  1  set with rsp_vld when the transaction timed out
- m_cmd  out  CMD_WIDTH  command to SPI master
- m_cmd_vld  out  1  command valid to master
- m_cmd_rdy  in  1  master idle/ready
- m_read_vld  in  1  master read data valid, 1 cycle
- m_read_data  in  READ_WIDTH  master read data

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req_vld, the winner is the first set bit searching upward (with wrap) from last_grant+1. Assert req_rdy[winner] combinationally this cycle. Latch req_cmd[winner], owner index, and is_read = ~cmd[CMD_WIDTH-1]. Update last_grant. Next state ISSUE.
- ISSUE: m_cmd_vld=1, m_cmd=latched command, both held stable until m_cmd_vld&&m_cmd_rdy. On handshake: clear busy_seen and the timeout counter, then go to WAIT.
- WAIT, read: complete on m_read_vld; capture m_read_data.
- WAIT, write: set busy_seen when m_cmd_rdy=0. Complete on the first cycle with m_cmd_rdy=1 and busy_seen=1.
- Completion: next cycle, rsp_vld[owner]=1 and rsp_data valid (0 for writes), rsp_err=0. Next state IDLE.
- Timeout: the counter increments every WAIT cycle. When it reaches TIMEOUT-1 without completion, pulse rsp_vld[owner] with rsp_err=1 and rsp_data=0, then go to IDLE.
- Completion and timeout in the same cycle: completion wins, rsp_err=0.
- m_read_vld outside WAIT, or during a write: ignored.
- req_vld of non-winners is not acknowledged. Requesters hold req_vld/req_cmd until req_rdy (valid/ready). Deasserting req_vld before acceptance withdraws the request.
- No new grant is issued while ISSUE/WAIT is active; a pending rsp_vld cycle overlaps the IDLE grant of the next request.

## Timing
- Reset: state IDLE; req_rdy=0, rsp_vld=0, rsp_data=0, rsp_err=0, m_cmd=0, m_cmd_vld=0; last_grant=NUM_REQ-1, so requester 0 wins first; counters and busy_seen 0.
- Reset mid-transaction aborts silently, with no rsp_vld.
- Grant latency: req_vld seen in IDLE gives req_rdy in the same cycle and m_cmd_vld the next cycle.
- Response latency: rsp_vld is registered, 1 cycle after the completion condition.
- Minimum occupancy per command: IDLE 1 + ISSUE ≥1 + WAIT ≥1 cycles; back-to-back grants are every 3 cycles at best.
- Timeout counter width: $clog2(TIMEOUT+1); it saturates and never wraps.

## Structure
- Package spi_arb_pkg: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), RW bit index helper, and default widths.
- Sub-module rr_pick: combinational round-robin priority picker (req vector, last_grant → one-hot grant, index, any). It is reusable and unit-testable.
- Top: FSM, command/owner/is_read registers, busy_seen flag, timeout counter, response registers.

## Test plan
- Single read: req_vld[2]=1, cmd=12'h0A5 -> req_rdy[2] the same cycle; m_cmd=12'h0A5 with m_cmd_vld next cycle; master returns m_read_data=8'h3C -> rsp_vld=4'b0100, rsp_data=8'h3C, rsp_err=0.
- Single write: req_vld[0], cmd=12'h8F1; master drops m_cmd_rdy for 12 cycles then raises it -> rsp_vld=4'b0001 one cycle later, rsp_data=0.
- Fairness: all four req_vld held continuously with write commands -> grant order 0,1,2,3,0,1 and no requester granted twice before the others.
- Timeout: TIMEOUT=16, read issued, master never asserts m_read_vld -> rsp_vld[owner] and rsp_err=1 exactly 16 WAIT cycles after the handshake; the FSM then returns to IDLE and serves the next request.
- Race: m_read_vld on the same cycle the counter hits TIMEOUT-1 -> rsp_err=0 and rsp_data=master data.
- Reset mid-WAIT: deassert rst_n during a read -> all outputs 0 immediately, no rsp_vld after release, and requester 0 wins the first grant.
